// File: rtl/bingo_number_entry.sv
// bingo_number_entry: assembles 1-2 digit Bingo numbers, range/duplicate checks them, offers them over valid/ready.
// Optional macro ENTRY_TIMEOUT_EN discards a stale partial entry after TIMEOUT_CYCLES idle cycles.
`default_nettype none

module bingo_number_entry #(
  parameter int MAX_NUM        = 25,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       enter_pulse,
  input  logic       clear_used,
  output logic [6:0] num_out,
  output logic       num_valid,
  input  logic       num_ready,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       busy
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_D1    = 2'd1;
  localparam logic [1:0] S_D2    = 2'd2;
  localparam logic [1:0] S_OFFER = 2'd3;
  localparam logic [6:0] C_MAX   = 7'(MAX_NUM);
  localparam logic [3:0] C_BLANK = 4'd15;

  logic [1:0]       state_q, state_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic [MAX_NUM:0] used_q, used_d;
  logic [6:0]       num_out_q, num_out_d;
  logic             num_valid_q, num_valid_d;
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [6:0]       w_value;
  logic             w_dup;
  logic [MAX_NUM:0] w_onehot;
  logic             w_digit_ok;
  logic             w_timeout;

  assign w_digit_ok = digit_valid && (digit <= 4'd9);
  // tens*10 built from shifts to keep the datapath multiplier-free
  assign w_value = (state_q == S_D2)
                 ? (({3'b0, tens_q} << 3) + ({3'b0, tens_q} << 1) + {3'b0, ones_q})
                 : {3'b0, ones_q};

  always_comb begin
    w_dup    = 1'b0;
    w_onehot = '0;
    for (int i = 0; i <= MAX_NUM; i++) begin
      if (w_value == 7'(i)) begin
        w_dup       = used_q[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_counting;

  assign w_timeout  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign w_counting = ((state_q == S_D1) || (state_q == S_D2)) && (state_d == state_q)
                      && !clear_used && !enter_pulse && !w_digit_ok;
  assign cnt_d      = w_counting ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    used_d      = used_q;
    num_out_d   = num_out_q;
    num_valid_d = num_valid_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    if (clear_used) begin
      used_d      = '0;
      state_d     = S_EMPTY;
      num_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (enter_pulse) begin
            err_pulse_d = 1'b1;
            err_code_d  = 2'd1;
          end else if (w_digit_ok) begin
            ones_d  = digit;
            state_d = S_D1;
          end
        end
        S_D1, S_D2: begin
          if (enter_pulse) begin
            state_d = S_EMPTY;
            if ((w_value == 7'd0) || (w_value > C_MAX)) begin
              err_pulse_d = 1'b1;
              err_code_d  = 2'd2;
            end else if (w_dup) begin
              err_pulse_d = 1'b1;
              err_code_d  = 2'd3;
            end else begin
              num_out_d   = w_value;
              used_d      = used_q | w_onehot;
              num_valid_d = 1'b1;
              state_d     = S_OFFER;
            end
          end else if (w_digit_ok) begin
            tens_d  = ones_q;
            ones_d  = digit;
            state_d = S_D2;
          end else if (w_timeout) begin
            state_d = S_EMPTY;
          end
        end
        default: begin
          if (num_ready) begin
            state_d     = S_EMPTY;
            num_valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      used_q      <= '0;
      num_out_q   <= 7'd0;
      num_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      used_q      <= used_d;
      num_out_q   <= num_out_d;
      num_valid_q <= num_valid_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  // OFFER shows the digits that formed num_out; a leading zero is blanked
  always_comb begin
    disp_tens = C_BLANK;
    disp_ones = C_BLANK;
    case (state_q)
      S_D1:    disp_ones = ones_q;
      S_D2: begin
        disp_tens = tens_q;
        disp_ones = ones_q;
      end
      S_OFFER: begin
        disp_tens = (num_out_q < 7'd10) ? C_BLANK : tens_q;
        disp_ones = ones_q;
      end
      default: ;
    endcase
  end

  assign num_out   = num_out_q;
  assign num_valid = num_valid_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q == S_OFFER);

endmodule

`default_nettype wire

// File: tb/tb_bingo_number_entry.sv
// Directed self-checking bench for bingo_number_entry (MAX_NUM=25).
`default_nettype none

module tb_bingo_number_entry;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0;
  logic       enter_pulse = 1'b0;
  logic       clear_used = 1'b0;
  logic       num_ready = 1'b0;
  logic [6:0] num_out;
  logic       num_valid;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic       busy;

  int total = 0;
  int bad   = 0;

  bingo_number_entry #(.MAX_NUM(25), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .digit(digit), .digit_valid(digit_valid),
    .enter_pulse(enter_pulse), .clear_used(clear_used), .num_out(num_out),
    .num_valid(num_valid), .num_ready(num_ready), .err_pulse(err_pulse),
    .err_code(err_code), .disp_tens(disp_tens), .disp_ones(disp_ones), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dig(input logic [3:0] d);
    digit = d; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic ent();
    enter_pulse = 1'b1;
    tick();
    enter_pulse = 1'b0;
  endtask

  task automatic take();
    num_ready = 1'b1;
    tick();
    num_ready = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_valid", num_valid, 0);
    chk("rst_out", num_out, 0);
    chk("rst_code", err_code, 0);
    chk("rst_tens", disp_tens, 15);
    chk("rst_ones", disp_ones, 15);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // accept 12, then reject the duplicate
    dig(1);  chk("d1_disp", disp_ones, 1); chk("d1_tens", disp_tens, 15);
    dig(2);  chk("d2_tens", disp_tens, 1); chk("d2_ones", disp_ones, 2);
    ent();
    chk("acc12_valid", num_valid, 1); chk("acc12_out", num_out, 12);
    chk("acc12_busy", busy, 1); chk("acc12_tens", disp_tens, 1); chk("acc12_ones", disp_ones, 2);
    chk("acc12_noerr", err_pulse, 0);
    take();
    chk("hs_valid", num_valid, 0); chk("hs_tens", disp_tens, 15);
    dig(1); dig(2); ent();
    chk("dup_pulse", err_pulse, 1); chk("dup_code", err_code, 3); chk("dup_valid", num_valid, 0);
    tick();
    chk("dup_pulse_1cyc", err_pulse, 0);

    // rejections
    dig(3); dig(0); ent();
    chk("rng30_pulse", err_pulse, 1); chk("rng30_code", err_code, 2);
    ent();
    chk("empty_pulse", err_pulse, 1); chk("empty_code", err_code, 1);
    dig(0); ent();
    chk("zero_code", err_code, 2);
    dig(12);
    chk("dig12_tens", disp_tens, 15); chk("dig12_ones", disp_ones, 15);
    ent();
    chk("dig12_code", err_code, 1);

    // sliding window and enter-over-digit priority
    dig(1); dig(2); dig(5);
    chk("slide_tens", disp_tens, 2); chk("slide_ones", disp_ones, 5);
    ent();
    chk("acc25_out", num_out, 25); chk("acc25_valid", num_valid, 1);
    take();
    dig(7);
    digit = 4'd3; digit_valid = 1'b1; enter_pulse = 1'b1;
    tick();
    digit_valid = 1'b0; enter_pulse = 1'b0;
    chk("acc7_out", num_out, 7); chk("acc7_valid", num_valid, 1);
    chk("acc7_tens", disp_tens, 15); chk("acc7_ones", disp_ones, 7);
    take();

    // back-pressure with ignored inputs
    dig(9); ent();
    chk("acc9_out", num_out, 9);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) dig(5); else ent();
      chk("hold_valid", num_valid, 1); chk("hold_out", num_out, 9); chk("hold_busy", busy, 1);
    end
    take();
    chk("rel_valid", num_valid, 0); chk("rel_tens", disp_tens, 15); chk("rel_ones", disp_ones, 15);
    ent();
    chk("rel_empty_pulse", err_pulse, 1); chk("rel_empty_code", err_code, 1);

    // asynchronous reset mid-D2
    dig(1); dig(3);
    chk("pre_rst_tens", disp_tens, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_tens", disp_tens, 15); chk("async_ones", disp_ones, 15);
    chk("async_code", err_code, 0);
    #2 rst = 1'b1;
    tick();
    clear_used = 1'b1; tick(); clear_used = 1'b0;
    dig(1); dig(2); ent();
    chk("new_acc12", num_out, 12); chk("new_acc12_valid", num_valid, 1);
    clear_used = 1'b1; tick(); clear_used = 1'b0;
    chk("clr_offer_valid", num_valid, 0); chk("clr_offer_busy", busy, 0);
    dig(1); dig(2); ent();
    chk("clr_reacc12", num_valid, 1);
    take();
    dig(4);
    clear_used = 1'b1; enter_pulse = 1'b1; tick(); clear_used = 1'b0; enter_pulse = 1'b0;
    chk("clr_enter_pulse", err_pulse, 0); chk("clr_enter_valid", num_valid, 0);
    chk("clr_enter_ones", disp_ones, 15); chk("clr_enter_code", err_code, 0);

`ifdef ENTRY_TIMEOUT_EN
    dig(4);
    repeat (15) tick();
    chk("to_hold", disp_ones, 4);
    tick();
    chk("to_blank", disp_ones, 15); chk("to_nopulse", err_pulse, 0);
    dig(4);
    repeat (14) tick();
    dig(5);
    repeat (15) tick();
    chk("to_restart_hold", disp_tens, 4);
    tick();
    chk("to_restart_blank", disp_tens, 15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/bingo_number_entry.md
Name: bingo_number_entry

Overview:
- Sits directly downstream of the keyboard handler; consumes its decoded digit strobes and its enter pulse.
- Assembles one- or two-digit Bingo numbers and range-checks them against MAX_NUM.
- Rejects numbers already called this game, using an internal used-bitmap.
- Hands accepted numbers to the game logic over a valid/ready handshake, and drives the two digits for the seven-segment entry display.

Parameters:
- MAX_NUM, 25, largest legal number; legal range is 1..99.
- TIMEOUT_CYCLES, 100_000_000, idle cycles before a partial entry is discarded (only with ENTRY_TIMEOUT_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- digit  input  4  decoded digit value, 0..9.
- digit_valid  input  1  one-cycle strobe; digit is meaningful this cycle.
- enter_pulse  input  1  one-cycle Enter strobe.
- clear_used  input  1  one-cycle new-game strobe; clears the used-bitmap.
- num_out  output  7  accepted number.
- num_valid  output  1  num_out is valid; held until handshake completes.
- num_ready  input  1  game logic accepts num_out this cycle.
- err_pulse  output  1  one-cycle rejection strobe.
- err_code  output  2  last error: 0 none, 1 empty-enter, 2 out-of-range, 3 duplicate.
- disp_tens  output  4  tens digit for display; 15 = blank.
- disp_ones  output  4  ones digit for display; 15 = blank.
- busy  output  1  high while in OFFER.

Behaviour:
- Reset (rst low, asynchronous), all registers return to:
  - state EMPTY, used-bitmap all 0;
  - num_out 0, num_valid 0, err_pulse 0, err_code 0;
  - disp_tens 15, disp_ones 15, busy 0.
- Registers: tens, ones (4b each), a used-bitmap of MAX_NUM+1 bits (bit 0 unused), and state.
- States and transitions:
  - EMPTY, on digit: ones<=digit, go to D1.
  - EMPTY, on enter: err_pulse, err_code=1, stay in EMPTY.
  - D1, on digit: tens<=ones, ones<=digit, go to D2.
  - D1, on enter: evaluate value = ones.
  - D2, on digit: tens<=ones, ones<=digit, stay in D2. This is a sliding window; only the last two digits are kept.
  - D2, on enter: evaluate value = tens*10+ones.
  - OFFER: num_valid=1, busy=1, num_out stable. digit_valid and enter_pulse are ignored. On a cycle with num_ready=1, go to EMPTY; num_valid is low the next cycle.
- Evaluate (registered; the result is visible the cycle after enter_pulse):
  - value==0 or value>MAX_NUM: err_pulse, err_code=2, go to EMPTY.
  - used[value]==1: err_pulse, err_code=3, go to EMPTY.
  - Otherwise: num_out<=value, used[value]<=1, num_valid<=1, go to OFFER.
  - Duplicate check uses the bitmap contents before this cycle's update.
- err_code holds its last value until the next error; it never returns to 0 except on reset.
- Ignored inputs: digit_valid with digit>9 is ignored.
- Simultaneous events and priority:
  - digit_valid and enter_pulse in the same cycle: enter wins, the digit is dropped.
  - clear_used has top priority. It clears the bitmap, forces EMPTY, drops num_valid, suppresses err_pulse, and discards any same-cycle digit/enter. err_code is unchanged.
- Display:
  - EMPTY: 15/15.
  - D1: 15/ones.
  - D2: tens/ones.
  - OFFER: decimal digits of num_out; tens=15 when num_out<10.
- Arithmetic: value is computed in 7 bits; tens*10 is implemented as (tens<<3)+(tens<<1).

Optional Feature:
- Macro: ENTRY_TIMEOUT_EN.
- With the macro:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs only in D1/D2.
  - It reloads to 0 on every accepted digit and on every state entry.
  - On reaching TIMEOUT_CYCLES it forces EMPTY and blanks the display, with no err_pulse and err_code unchanged.
  - Enter in the same cycle as the timeout takes priority over the timeout.
- Without the macro: a partial entry is held indefinitely and no counter is instantiated.

Test Plan:
1. Enter sequence, duplicate, and handshake:
   - Digits 1,2, then enter, num_ready=1 -> num_valid=1 the cycle after enter, num_out=12, display 1/2.
   - Then 1,2 again, enter -> err_pulse for 1 cycle, err_code=3, no num_valid.
2. Rejections with MAX_NUM=25, one check each:
   - 3,0 enter -> err_code=2.
   - 0 enter -> err_code=2.
   - Bare enter in EMPTY -> err_code=1.
   - Digit 12 with valid -> ignored, display stays 15/15.
3. Sliding window and priority:
   - Digits 1,2,5, enter -> num_out=25 accepted.
   - digit_valid and enter_pulse together after digit 7 -> num_out=7 is accepted and the same-cycle digit is dropped; display 15/7.
4. Back-pressure:
   - num_ready held low 10 cycles after acceptance of 9 -> num_valid stays 1, num_out=9, busy=1.
   - Digits/enter during the hold are ignored.
   - num_ready pulse -> num_valid=0 next cycle, display 15/15.
5. Reset and new game:
   - rst low mid-D2 -> outputs reset immediately, without waiting for clk.
   - After release, clear_used, then 1,2 enter -> 12 accepted again.
   - clear_used during OFFER -> num_valid drops next cycle.
6. With ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=16:
   - Digit 4 then 16 idle cycles -> EMPTY, display 15/15, no err_pulse.
   - Digit at cycle 15 restarts the count.
